uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that consumes the serial line driven by the `tx` block. It recovers 8-N-1 frames and presents each received byte on a parallel bus with a one-cycle valid strobe. It is the receive half of the UART pair: the `tx` output loops directly into `rx` in the pair-level bench, and in system use `rx` comes from an external pin.

## Interface
- `CLOCK_HZ`, 50_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line bit rate
- `CLKS_PER_BIT`, CLOCK_HZ/BAUD_RATE (integer floor, 434 at defaults), clocks per bit
- `HALF_BIT`, CLKS_PER_BIT/2 (217 at defaults), clocks from start edge to start-bit mid-point

Ports:
- `clk`  input  1  system clock, all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `rx`  input  1  asynchronous serial line, idle high
- `data`  output  8  last correctly framed byte
- `valid`  output  1  one-cycle pulse: `data` is new
- `busy_flag`  output  1  high while a frame is being received
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low

## Operation
- Input synchronizer: `rx` passes through two flops (`rx_s1`, `rx_s2`); both reset to 1. A third flop `rx_prev` holds the previous `rx_s2`. All decisions use `rx_s2`.
- Counter `cnt`: 0..CLKS_PER_BIT-1. Bit index: 0..7. Shift register: 8 bits, filled LSB first.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: arms on a falling edge (`rx_prev`=1, `rx_s2`=0), then goes to START with `cnt`=0. A line that is held low never re-arms.
- START: when `cnt`==HALF_BIT-1, sample `rx_s2`.
  - If 0: go to DATA with `cnt`=0 and bit index 0.
  - If 1: treat as a glitch and go to IDLE with no output activity.
- DATA: when `cnt`==CLKS_PER_BIT-1, shift `rx_s2` into bit [index] and reset `cnt`. After bit 7, go to STOP.
- STOP: when `cnt`==CLKS_PER_BIT-1, sample `rx_s2`.
  - If 1: load `data` from the shift register, pulse `valid` for one cycle, go to IDLE.
  - If 0: pulse `frame_err` for one cycle, leave `data` unchanged, go to IDLE.
- `busy_flag` = 1 in START, DATA and STOP; 0 in IDLE.
- `valid` and `frame_err` are never high in the same cycle.
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `busy_flag`=0, state IDLE, `cnt`=0.
- Reset mid-frame: abort immediately and apply all reset values. The partial byte is discarded and nothing is pulsed.

## Timing
- Start-detect latency: 3 edges from the first clock edge that samples `rx` low to the START transition (2 synchronizer edges plus the edge-detect register).
- Sample points:
  - Start bit: HALF_BIT clocks after entering START.
  - Data bit k: HALF_BIT + (k+1)·CLKS_PER_BIT clocks after entering START.
  - Stop bit: HALF_BIT + 9·CLKS_PER_BIT clocks after entering START.
- `valid`/`frame_err` are registered and rise on the edge after the stop sample. At defaults, the total is 4127 ±1 clocks from the start-bit falling edge on `rx`; the ±1 covers synchronizer phase.
- Back-to-back frames: the FSM is back in IDLE at mid-stop-bit, so a new start edge arriving at or after the end of the stop bit is accepted with no gap required.
- Tolerance: sampling at mid-bit tolerates ±4% total baud mismatch over 10 bits.

## Test plan
- Loopback with `tx` at default parameters, send 8'hAA.
  - Exactly one `valid` pulse with `data`=8'hAA, `frame_err` never high.
  - `busy_flag` high for about 4127 clocks, then low.
- Back-to-back frames: send 8'h55 then 8'hA5 with no idle gap.
  - Two `valid` pulses, about 4340 clocks apart, carrying 8'h55 then 8'hA5.
- Glitch: drive `rx` low for 100 clocks, then high.
  - `busy_flag` high for HALF_BIT clocks, then back to IDLE.
  - No `valid`, no `frame_err`, `data` unchanged.
- Framing error:
  - Hand-drive frame 8'h3C with the stop bit low, then hold `rx` low for 20 bit times.
    - One `frame_err` pulse, no `valid`, `data` keeps its previous value.
    - No new frame starts while `rx` stays low.
  - Return `rx` high, then send 8'h81: `valid` pulses with `data`=8'h81.
- Reset mid-frame:
  - Assert `rst` for 1 cycle during bit 4 of an 8'hF0 frame. All outputs go to reset values on the next edge, and no `valid` appears for the aborted frame.
  - A following 8'h0F frame is received correctly.
- Baud skew: drive 8'hC3 at BAUD_RATE ×1.03 and again at ×0.97.
  - Both frames produce `valid` with `data`=8'hC3.

Source files
------------

// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: serial input plus the received-byte bus.
// The receiver holds the master modport; whoever consumes bytes and drives the line holds the slave one.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       busy_flag;
   logic       frame_err;

   modport master (
      input  rx,
      output data,
      output valid,
      output busy_flag,
      output frame_err
   );

   modport slave (
      output rx,
      input  data,
      input  valid,
      input  busy_flag,
      input  frame_err
   );
endinterface

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: two-flop synchronizer, falling-edge start detect, mid-bit sampling,
// one-cycle valid / frame_err strobes.
module uart_rx #(
   parameter int CLOCK_HZ     = 50_000_000,
   parameter int BAUD_RATE    = 115_200,
   parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.master bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic          rx_s1, rx_s2, rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          cnt_clr, shift_en, load, err;

   // State register. The reset is synchronous and active-high so it only acts on a clock edge.
   // NOTE: every flop here is assigned with <= so all registers see the pre-edge values of each other.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and datapath control.
   // NOTE: every output of this block gets a default first, otherwise a missed branch infers a latch.
   always_comb begin
      state_n  = state;
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      load     = 1'b0;
      err      = 1'b0;
      unique case (state)
         IDLE: if (rx_prev && !rx_s2) begin
            state_n = START;
            cnt_clr = 1'b1;
         end
         START: if (cnt == HALF_LAST) begin
            cnt_clr = 1'b1;
            state_n = rx_s2 ? IDLE : DATA;   // a line already back high was a glitch
         end
         DATA: if (cnt == BIT_LAST) begin
            cnt_clr  = 1'b1;
            shift_en = 1'b1;
            if (idx == 3'd7) state_n = STOP;
         end
         STOP: if (cnt == BIT_LAST) begin
            cnt_clr = 1'b1;
            state_n = IDLE;
            load    = rx_s2;
            err     = !rx_s2;
         end
         default: state_n = IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      bus.busy_flag = (state != IDLE);
   end

   // Synchronizer, bit timing, shift register and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_prev       <= 1'b1;
         cnt           <= '0;
         idx           <= '0;
         shreg         <= '0;
         bus.data      <= 8'h00;
         bus.valid     <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         rx_s1   <= bus.rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;

         if (cnt_clr || state == IDLE) cnt <= '0;
         else                          cnt <= cnt + 1'b1;

         if (state == START)  idx <= '0;
         else if (shift_en)   idx <= idx + 1'b1;

         if (shift_en) shreg[idx] <= rx_s2;

         if (load) bus.data <= shreg;
         bus.valid     <= load;
         bus.frame_err <= err;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized and directed frames, scoreboard queue of expected
// bytes, and a negedge monitor that compares each strobe against the head of the queue.
module tb_uart_rx;
   localparam int CLOCK_HZ   = 5_000_000;
   localparam int BAUD       = 115_200;
   localparam int CPB        = CLOCK_HZ / BAUD;
   localparam int HALF       = CPB / 2;
   localparam int LAT        = HALF + 9 * CPB + 3;
   localparam int BUSY_FRAME = HALF + 9 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if bus ();

   uart_rx #(.CLOCK_HZ(CLOCK_HZ), .BAUD_RATE(BAUD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   typedef struct {
      logic [7:0] data;
      bit         err;
      int         t0;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_data = 8'h00;
   int         busy_run = 0;
   int         last_run = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, got, got, exp, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst) begin
         model_data = 8'h00;
         busy_run   = 0;
      end else begin
         if (bus.busy_flag) busy_run++;
         else if (busy_run > 0) begin
            last_run = busy_run;
            busy_run = 0;
         end
         if (bus.valid || bus.frame_err) begin
            check("exclusive_strobes", int'(bus.valid & bus.frame_err), 0);
            if (sb.size() == 0) begin
               check("unexpected_output", int'({bus.valid, bus.frame_err}), 0);
            end else begin
               mon_e = sb.pop_front();
               check("strobe_kind", int'(bus.frame_err), int'(mon_e.err));
               check("latency", cyc - mon_e.t0, LAT);
               if (!mon_e.err) begin
                  check("data", int'(bus.data), int'(mon_e.data));
                  model_data = mon_e.data;
               end else begin
                  check("data_kept_on_err", int'(bus.data), int'(model_data));
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      if (cyc > 90_000) begin
         $display("FAIL watchdog: cycle %0d exceeded budget 90000", cyc);
         $fatal(1, "watchdog");
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},      int'(bus.data), 0);
      check({tag, "_valid"},     int'(bus.valid), 0);
      check({tag, "_busy"},      int'(bus.busy_flag), 0);
      check({tag, "_frame_err"}, int'(bus.frame_err), 0);
   endtask

   // Drives one frame; bit k of the line starts k*CPB*num/den cycles after the start edge.
   // Leaves rx at the stop-bit level so the caller decides what follows.
   task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int num,
                             input int den, input bit abort);
      int         t0;
      logic [9:0] bits;
      t0   = cyc;
      bits = {stop_bit, b, 1'b0};
      if (!abort) sb.push_back(exp_t'{data: b, err: !stop_bit, t0: t0});
      for (int k = 0; k < 10; k++) begin
         bus.rx = bits[k];
         if (abort && k == 4) begin
            idle(CPB / 2);
            rst = 1'b1;
            idle(1);
            rst = 1'b0;
            check_reset_outputs("midframe_reset");
         end
         while (cyc - t0 < ((k + 1) * CPB * num) / den) idle(1);
      end
   endtask

   initial begin
      int busy_seen;
      int w;
      logic [7:0] rb;
      bit rerr;

      bus.rx = 1'b1;
      idle(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      idle(2);

      // Single frame, busy window length.
      send_frame(8'hAA, 1'b1, 1, 1, 1'b0);
      idle(CPB);
      check("busy_run_aa", last_run, BUSY_FRAME);

      // Back-to-back frames with no idle gap.
      send_frame(8'h55, 1'b1, 1, 1, 1'b0);
      send_frame(8'hA5, 1'b1, 1, 1, 1'b0);
      idle(CPB);

      // Short low glitch: START for exactly HALF cycles, then IDLE with no strobes.
      bus.rx = 1'b0;
      idle(10);
      bus.rx = 1'b1;
      idle(2 * CPB);
      check("busy_run_glitch", last_run, HALF);
      check("glitch_data", int'(bus.data), int'(8'hA5));

      // Framing error, then line held low: no new frame may start.
      send_frame(8'h3C, 1'b0, 1, 1, 1'b0);
      busy_seen = 0;
      repeat (20 * CPB) begin
         @(negedge clk);
         if (bus.busy_flag) busy_seen++;
      end
      @(posedge clk);
      #1;
      check("held_low_busy", busy_seen, 0);
      check("held_low_data", int'(bus.data), int'(8'hA5));
      bus.rx = 1'b1;
      idle(CPB);
      send_frame(8'h81, 1'b1, 1, 1, 1'b0);
      idle(CPB);

      // Reset during bit 4, then a clean frame.
      send_frame(8'hF0, 1'b1, 1, 1, 1'b1);
      idle(CPB);
      send_frame(8'h0F, 1'b1, 1, 1, 1'b0);
      idle(CPB);

      // Baud skew: 3% fast and 3% slow.
      send_frame(8'hC3, 1'b1, 100, 103, 1'b0);
      idle(CPB);
      check("busy_run_fast", last_run, BUSY_FRAME);
      send_frame(8'hC3, 1'b1, 100, 97, 1'b0);
      idle(CPB);

      // Random bytes, occasional framing errors, random gaps (zero after good frames).
      for (int i = 0; i < 24; i++) begin
         rb   = 8'($urandom);
         rerr = ($urandom_range(0, 7) == 0);
         send_frame(rb, !rerr, 1, 1, 1'b0);
         if (rerr) begin
            bus.rx = 1'b1;
            idle($urandom_range(3, CPB));
         end else begin
            idle($urandom_range(0, CPB));
         end
      end

      w = 0;
      while (sb.size() != 0 && w < LAT + 10) begin
         idle(1);
         w++;
      end
      check("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
